// File: rtl/stat_pkg.sv
// Shared types, widths and the saturating adder for the sufficient-statistic accumulator.
package stat_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam int N_W  = 16;  // sample count width
  localparam int S1_W = 16;  // first-order sums
  localparam int S2_W = 32;  // second-order sums

  // Adds with a ceiling of max; o_sat flags that the true sum exceeded it.
  function automatic logic [S2_W-1:0] sat_add(input  logic [S2_W-1:0] a,
                                               input  logic [S2_W-1:0] b,
                                               input  logic [S2_W-1:0] max,
                                               output logic            o_sat);
    logic [S2_W:0] sum;
    sum   = {1'b0, a} + {1'b0, b};
    o_sat = (sum > {1'b0, max});
    return o_sat ? max : sum[S2_W-1:0];
  endfunction

endpackage

// File: rtl/stat_accum_if.sv
// Sample stream in, statistics out. The master side feeds samples and consumes
// statistics; stat_accum sits on the slave side.
interface stat_accum_if #(parameter int DW = 8);
  logic                         s_valid;
  logic                         s_ready;
  logic [DW-1:0]                s_x;
  logic [DW-1:0]                s_y;
  logic                         stat_valid;
  logic                         stat_ready;
  logic [stat_pkg::N_W-1:0]     n;
  logic [stat_pkg::S1_W-1:0]    sig_x;
  logic [stat_pkg::S1_W-1:0]    sig_y;
  logic [stat_pkg::S2_W-1:0]    sig_xy;
  logic [stat_pkg::S2_W-1:0]    sig_x2;
  logic [stat_pkg::S2_W-1:0]    sig_y2;
  logic                         ovf;

  modport master (
    output s_valid, s_x, s_y, stat_ready,
    input  s_ready, stat_valid, n, sig_x, sig_y, sig_xy, sig_x2, sig_y2, ovf
  );

  modport slave (
    input  s_valid, s_x, s_y, stat_ready,
    output s_ready, stat_valid, n, sig_x, sig_y, sig_xy, sig_x2, sig_y2, ovf
  );
endinterface

// File: rtl/stat_mac.sv
// Stage 1: registers an accepted sample together with its three products.
module stat_mac #(
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_en,
  input  logic [DW-1:0]   i_x,
  input  logic [DW-1:0]   i_y,
  output logic            o_valid,
  output logic [DW-1:0]   o_x,
  output logic [DW-1:0]   o_y,
  output logic [2*DW-1:0] o_xx,
  output logic [2*DW-1:0] o_yy,
  output logic [2*DW-1:0] o_xy
);

  logic            r_valid;
  logic [DW-1:0]   r_x, r_y;
  logic [2*DW-1:0] r_xx, r_yy, r_xy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_valid <= 1'b0;
    else        r_valid <= i_en;
  end

  // NOTE: data registers carry no reset; r_valid alone decides whether they are consumed.
  always_ff @(posedge clk) begin
    if (i_en) begin
      r_x  <= i_x;
      r_y  <= i_y;
      r_xx <= (2*DW)'(i_x) * (2*DW)'(i_x);
      r_yy <= (2*DW)'(i_y) * (2*DW)'(i_y);
      r_xy <= (2*DW)'(i_x) * (2*DW)'(i_y);
    end
  end

  assign o_valid = r_valid;
  assign o_x     = r_x;
  assign o_y     = r_y;
  assign o_xx    = r_xx;
  assign o_yy    = r_yy;
  assign o_xy    = r_xy;

endmodule

// File: rtl/stat_accum.sv
// Window controller and stage-2 saturating accumulators for n, Σx, Σy, Σxy, Σx², Σy².
module stat_accum
  import stat_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [N_W-1:0]   win_len,
  output logic             busy,
  stat_accum_if.slave      bus
);

  localparam logic [S2_W-1:0] MAX_S1 = S2_W'({S1_W{1'b1}});
  localparam logic [S2_W-1:0] MAX_S2 = '1;

  state_t           r_state, w_next;
  logic [N_W-1:0]   r_len, r_cnt;
  logic             w_start_acc, w_accept, w_last;
  logic             w_m_valid;
  logic [DW-1:0]    w_m_x, w_m_y;
  logic [2*DW-1:0]  w_m_xx, w_m_yy, w_m_xy;
  logic [S1_W-1:0]  r_sx, r_sy, w_sx, w_sy;
  logic [S2_W-1:0]  r_sxy, r_sxx, r_syy, w_sxy, w_sxx, w_syy;
  logic             r_ovf;
  logic [4:0]       w_sat;

  assign w_start_acc = start && (r_state == ST_IDLE);
  assign bus.s_ready = (r_state == ST_ACCUM) && (r_cnt < r_len);
  assign w_accept    = bus.s_valid && bus.s_ready;
  assign w_last      = w_accept && (r_cnt == r_len - N_W'(1));

  stat_mac #(.DW(DW)) u_mac (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (w_accept),
    .i_x     (bus.s_x),
    .i_y     (bus.s_y),
    .o_valid (w_m_valid),
    .o_x     (w_m_x),
    .o_y     (w_m_y),
    .o_xx    (w_m_xx),
    .o_yy    (w_m_yy),
    .o_xy    (w_m_xy)
  );

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // NOTE: w_next takes its default before the case so no path can infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_next = (win_len == '0) ? ST_DONE : ST_ACCUM;
      ST_ACCUM: if (w_last) w_next = ST_DRAIN;
      ST_DRAIN: w_next = ST_DONE;
      ST_DONE:  if (bus.stat_ready) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len <= '0;
      r_cnt <= '0;
    end else if (w_start_acc) begin
      r_len <= win_len;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= r_cnt + N_W'(1);
    end
  end

  always_comb begin
    w_sat = '0;
    w_sx  = S1_W'(sat_add(S2_W'(r_sx), S2_W'(w_m_x), MAX_S1, w_sat[0]));
    w_sy  = S1_W'(sat_add(S2_W'(r_sy), S2_W'(w_m_y), MAX_S1, w_sat[1]));
    w_sxy = sat_add(r_sxy, S2_W'(w_m_xy), MAX_S2, w_sat[2]);
    w_sxx = sat_add(r_sxx, S2_W'(w_m_xx), MAX_S2, w_sat[3]);
    w_syy = sat_add(r_syy, S2_W'(w_m_yy), MAX_S2, w_sat[4]);
  end

  // Sums clear only on an accepted start, so results hold through DONE and IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sx <= '0; r_sy <= '0; r_sxy <= '0; r_sxx <= '0; r_syy <= '0;
      r_ovf <= 1'b0;
    end else if (w_start_acc) begin
      r_sx <= '0; r_sy <= '0; r_sxy <= '0; r_sxx <= '0; r_syy <= '0;
      r_ovf <= 1'b0;
    end else if (w_m_valid) begin
      r_sx  <= w_sx;
      r_sy  <= w_sy;
      r_sxy <= w_sxy;
      r_sxx <= w_sxx;
      r_syy <= w_syy;
      r_ovf <= r_ovf | (|w_sat);
    end
  end

  assign bus.stat_valid = (r_state == ST_DONE);
  assign busy           = (r_state != ST_IDLE);
  assign bus.n          = r_cnt;
  assign bus.sig_x      = r_sx;
  assign bus.sig_y      = r_sy;
  assign bus.sig_xy     = r_sxy;
  assign bus.sig_x2     = r_sxx;
  assign bus.sig_y2     = r_syy;
  assign bus.ovf        = r_ovf;

endmodule

// File: tb/tb_stat_accum.sv
// Directed bench for stat_accum: inputs change and outputs are sampled on the falling edge.
module tb_stat_accum;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] win_len = '0;
  logic        busy;
  int          errors = 0;
  int          checks = 0;

  stat_accum_if #(.DW(8)) bus();

  stat_accum #(.DW(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .win_len (win_len),
    .busy    (busy),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  wire [144:0] stats = {bus.n, bus.sig_x, bus.sig_y, bus.sig_xy, bus.sig_x2, bus.sig_y2, bus.ovf};

  function automatic logic [144:0] pack(input logic [15:0] n, input logic [15:0] sx, input logic [15:0] sy,
                                        input logic [31:0] sxy, input logic [31:0] sx2,
                                        input logic [31:0] sy2, input logic ovf);
    return {n, sx, sy, sxy, sx2, sy2, ovf};
  endfunction

  // Pulse start for one cycle; returns on the falling edge after the accepting edge.
  task automatic do_start(input logic [15:0] len);
    start = 1'b1; win_len = len;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] x, input logic [7:0] y, input string tag);
    int t = 0;
    bus.s_valid = 1'b1; bus.s_x = x; bus.s_y = y;
    while (!bus.s_ready && t < 50) begin @(negedge clk); t++; end
    checks++;
    if (bus.s_ready !== 1'b1) begin
      errors++; $display("FAIL %s send: s_ready never rose (got %b, want 1)", tag, bus.s_ready);
    end
    @(negedge clk);
    bus.s_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int t = 0;
    while (!bus.stat_valid && t < 20) begin @(negedge clk); t++; end
    checks++;
    if (bus.stat_valid !== 1'b1) begin
      errors++; $display("FAIL %s wait: stat_valid=%b, want 1", tag, bus.stat_valid);
    end
  endtask

  task automatic finish_stat();
    bus.stat_ready = 1'b1;
    @(negedge clk);
    bus.stat_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus.s_valid = 1'b0; bus.s_x = '0; bus.s_y = '0; bus.stat_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (stats !== '0) begin errors++; $display("FAIL reset stats: got %h, want 0", stats); end
    checks++;
    if ({bus.s_ready, bus.stat_valid, busy} !== 3'b000) begin
      errors++; $display("FAIL reset flags: got %b, want 000", {bus.s_ready, bus.stat_valid, busy});
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.s_ready, bus.stat_valid, busy} !== 3'b000) begin
      errors++; $display("FAIL idle flags: got %b, want 000", {bus.s_ready, bus.stat_valid, busy});
    end
  endtask

  task automatic test_basic();
    logic [144:0] exp = pack(16'd3, 16'd9, 16'd12, 32'd44, 32'd35, 32'd56, 1'b0);
    do_start(16'd3);
    checks++;
    if ({bus.s_ready, busy} !== 2'b11) begin
      errors++; $display("FAIL basic ready after start: got %b, want 11", {bus.s_ready, busy});
    end
    send(8'd1, 8'd2, "basic");
    send(8'd3, 8'd4, "basic");
    send(8'd5, 8'd6, "basic");
    checks++;
    if ({bus.s_ready, bus.stat_valid} !== 2'b00) begin
      errors++; $display("FAIL basic drain: ready/valid got %b, want 00", {bus.s_ready, bus.stat_valid});
    end
    @(negedge clk);
    checks++;
    if (bus.stat_valid !== 1'b1) begin
      errors++; $display("FAIL basic latency: stat_valid got %b, want 1", bus.stat_valid);
    end
    checks++;
    if (stats !== exp) begin errors++; $display("FAIL basic stats: got %h, want %h", stats, exp); end
    finish_stat();
    checks++;
    if ({bus.stat_valid, busy} !== 2'b00 || stats !== exp) begin
      errors++; $display("FAIL basic hold in idle: flags %b stats %h, want 00 %h",
                         {bus.stat_valid, busy}, stats, exp);
    end
  endtask

  // Starts in the IDLE cycle right after the previous handshake.
  task automatic test_gaps();
    logic [144:0] exp = pack(16'd3, 16'd9, 16'd12, 32'd44, 32'd35, 32'd56, 1'b0);
    int gaps[3] = '{1, 0, 3};
    logic [7:0] xs[3] = '{8'd1, 8'd3, 8'd5};
    logic [7:0] ys[3] = '{8'd2, 8'd4, 8'd6};
    do_start(16'd3);
    for (int i = 0; i < 3; i++) begin
      repeat (gaps[i]) @(negedge clk);
      send(xs[i], ys[i], "gaps");
    end
    wait_valid("gaps");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus.stat_valid !== 1'b1 || stats !== exp) begin
        errors++; $display("FAIL gaps stall %0d: valid %b stats %h, want 1 %h", i, bus.stat_valid, stats, exp);
      end
    end
    finish_stat();
  endtask

  task automatic test_saturate();
    logic [144:0] exp = pack(16'd258, 16'hFFFF, 16'hFFFF, 32'd16776450, 32'd16776450, 32'd16776450, 1'b1);
    do_start(16'd258);
    for (int i = 0; i < 258; i++) send(8'd255, 8'd255, "sat");
    checks++;
    if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL sat ready after last: got %b, want 0", bus.s_ready); end
    wait_valid("sat");
    checks++;
    if (stats !== exp) begin errors++; $display("FAIL sat stats: got %h, want %h", stats, exp); end
    finish_stat();
  endtask

  task automatic test_zero_len();
    do_start(16'd0);
    checks++;
    if ({bus.stat_valid, bus.s_ready} !== 2'b10) begin
      errors++; $display("FAIL zero valid/ready: got %b, want 10", {bus.stat_valid, bus.s_ready});
    end
    checks++;
    if (stats !== '0) begin errors++; $display("FAIL zero stats: got %h, want 0", stats); end
    finish_stat();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL zero busy after handshake: got %b, want 0", busy); end
  endtask

  task automatic test_mid_reset();
    logic [144:0] exp = pack(16'd1, 16'd7, 16'd3, 32'd21, 32'd49, 32'd9, 1'b0);
    do_start(16'd4);
    send(8'd9, 8'd9, "rst");
    send(8'd8, 8'd8, "rst");
    rst_n = 1'b0;
    #1;
    checks++;
    if (stats !== '0 || {bus.s_ready, bus.stat_valid, busy} !== 3'b000) begin
      errors++; $display("FAIL midrst values: stats %h flags %b, want 0 000",
                         stats, {bus.s_ready, bus.stat_valid, busy});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_start(16'd1);
    send(8'd7, 8'd3, "rst");
    wait_valid("rst");
    checks++;
    if (stats !== exp) begin errors++; $display("FAIL midrst new window: got %h, want %h", stats, exp); end
    finish_stat();
  endtask

  task automatic test_start_ignored();
    logic [144:0] exp = pack(16'd2, 16'd11, 16'd21, 32'd201, 32'd101, 32'd401, 1'b0);
    do_start(16'd2);
    send(8'd10, 8'd20, "ign");
    start = 1'b1; win_len = 16'd9; bus.stat_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; bus.stat_ready = 1'b0;
    checks++;
    if ({busy, bus.s_ready, bus.n} !== {2'b11, 16'd1}) begin
      errors++; $display("FAIL ign accum: busy/ready/n got %b %b %0d, want 1 1 1", busy, bus.s_ready, bus.n);
    end
    send(8'd1, 8'd1, "ign");
    wait_valid("ign");
    start = 1'b1; win_len = 16'd5;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (bus.stat_valid !== 1'b1 || stats !== exp) begin
      errors++; $display("FAIL ign done: valid %b stats %h, want 1 %h", bus.stat_valid, stats, exp);
    end
    finish_stat();
    checks++;
    if (busy !== 1'b0 || stats !== exp) begin
      errors++; $display("FAIL ign idle: busy %b stats %h, want 0 %h", busy, stats, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_saturate();
    test_zero_len();
    test_mid_reset();
    test_start_ignored();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stat_accum.md
# stat_accum

Streaming sufficient-statistic accumulator for the regression/outlier datapath. It accepts a window of (x, y) samples over a valid/ready handshake and accumulates n, Σx, Σy, Σxy, Σx², Σy². It presents the six results, widths matched to the n·MSE evaluator's inputs, behind a second valid/ready handshake. It is the producer side of the statistics interface consumed by the n·MSE block.

## Interface
- DW, 8: unsigned sample width of x and y (products 2·DW ≤ 32)
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse; begins a window (honoured only in IDLE)
- win_len  in  16  samples in window, sampled on accepted start
- s_valid  in  1  sample valid
- s_ready  out  1  sample ready
- s_x  in  DW  sample x, unsigned
- s_y  in  DW  sample y, unsigned
- stat_valid  out  1  statistics valid
- stat_ready  in  1  consumer accepts statistics
- n  out  16  accepted-sample count
- sig_x, sig_y  out  16  Σx, Σy
- sig_xy, sig_x2, sig_y2  out  32  Σxy, Σx², Σy²
- ovf  out  1  sticky: some sum saturated in this window
- busy  out  1  state ≠ IDLE

## Operation
- FSM states:
  - IDLE: start → ACCUM; clear all sums, n and ovf; latch win_len. With win_len = 0, go to DONE directly and present zero stats.
  - ACCUM: s_ready = 1 while accepted count < win_len. When the handshake accepts the last sample → DRAIN.
  - DRAIN: one cycle; the last product enters the sums → DONE.
  - DONE: stat_valid = 1. On stat_valid & stat_ready → IDLE.
- Sample accepted on s_valid & s_ready. Gaps in s_valid stall the window with no effect on sums.
- Two-stage datapath:
  - Stage 1 registers x, y, x·x, y·y, x·y and a valid bit on acceptance.
  - Stage 2 adds the stage-1 registers into the sums when the stage-1 valid bit is set.
- Width rules: operands zero-extended. Each sum saturates at all-ones of its own width, and any saturation sets ovf until the next start. n counts accepted samples and never exceeds win_len.
- Outputs n, sig_*, ovf hold their values from DONE through IDLE until the next accepted start.
- start outside IDLE is ignored. stat_ready outside DONE is ignored.

## Timing
- Reset: state IDLE; s_ready, stat_valid, busy, ovf = 0; n and all sig_* = 0; stage-1 valid = 0.
- start accepted at edge E → s_ready high in the cycle after E (win_len > 0).
- Last sample accepted at edge E0: s_ready low after E0. Sums are final and stat_valid goes high after E0+1, i.e. 2-edge latency.
- Back-to-back windows: start is accepted in the IDLE cycle following the stat handshake. There is no combinational path from start to s_ready or from stat_ready to s_ready.
- Reset asserted mid-window: immediate return to reset values. The partial window is discarded.

## Structure
- Package stat_pkg holds:
  - state enum (IDLE, ACCUM, DRAIN, DONE)
  - width constants N_W = 16, S1_W = 16, S2_W = 32
  - a saturating-add function
- Sub-module stat_mac holds the stage-1 product registers and valid bit.
- Top level holds the FSM, sample counter, and stage-2 saturating accumulators.

## Test plan
- win_len = 3, samples (1,2), (3,4), (5,6), s_valid held → n = 3, sig_x = 9, sig_y = 12, sig_xy = 44, sig_x2 = 35, sig_y2 = 56, ovf = 0. stat_valid rises 2 edges after the third accept.
- Same window with s_valid gaps of 0–3 cycles and stat_ready held low 5 cycles in DONE → identical results. Outputs stable while stalled.
- win_len = 258, every sample (255,255) → sig_x = sig_y = 16'hFFFF, sig_x2 = sig_y2 = sig_xy = 16776450, ovf = 1, n = 258.
- win_len = 0 → stat_valid high the cycle after start, all stats 0, no s_ready pulse.
- rst_n low after 2 of 4 samples → all outputs at reset values. A new start with win_len = 1 and sample (7,3) → sig_xy = 21, n = 1.
- start pulsed during ACCUM and DONE → ignored; the window completes unchanged.
